program_counter_stack: RTL and testbench

Parametrised program counter for the SAP-style CPU. It supports increment, absolute load (jump), and subroutine call/return through an internal return-address LIFO. The counter value is driven onto the shared tri-state bus when out_en is high, and is always visible on a dedicated debug output. The control sequencer drives its strobes; the count feeds the memory address register over the bus.

---
 rtl/sap_pkg.sv | 23 ++
 rtl/pc_return_stack.sv | 49 ++++
 rtl/program_counter_stack.sv | 101 ++++++++++
 tb/tb_program_counter_stack.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-style CPU: program-counter operation codes and
// the strobe priority resolver used by the program counter.
package sap_pkg;

  typedef enum logic [2:0] {
    PC_NONE,
    PC_INC,
    PC_LOAD,
    PC_CALL,
    PC_RET
  } pc_op_e;

  // Highest-priority strobe wins; the others in the same cycle are dropped.
  function automatic pc_op_e resolve_pc_op(input logic inc, input logic load,
                                           input logic call, input logic ret);
    if (ret)       return PC_RET;
    else if (call) return PC_CALL;
    else if (load) return PC_LOAD;
    else if (inc)  return PC_INC;
    else           return PC_NONE;
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Return-address LIFO for the program counter. Push is ignored when full and pop
// when empty; the top entry is readable combinationally so a return completes in one cycle.
module pc_return_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SP_W-1:0]  sp_q, sp_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  assign full    = (sp_q == SP_W'(DEPTH));
  assign empty   = (sp_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;
  assign wr_idx  = IDX_W'(sp_q);
  assign rd_idx  = IDX_W'(sp_q - SP_W'(1));
  assign top     = mem_q[rd_idx];

  always_comb begin
    sp_d = sp_q;
    if (do_push)     sp_d = sp_q + SP_W'(1);
    else if (do_pop) sp_d = sp_q - SP_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sp_q <= '0;
    else     sp_q <= sp_d;
  end

  // Entry contents are meaningless until pushed, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/program_counter_stack.sv
// SAP program counter: increment, jump, call/return via a return-address stack,
// tri-state bus drive plus an always-driven debug copy of the count.
module program_counter_stack
  import sap_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter int               STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load,
  input  logic             call,
  input  logic             ret,
  input  logic             halt,
  input  logic [WIDTH-1:0] din,
  input  logic             out_en,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] pc_q,
  output logic             wrapped,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  pc_op_e           op;
  logic [WIDTH-1:0] pc_d, pc_plus1, stack_top;
  logic             wrapped_q, wrapped_d;
  logic             stack_err_q, stack_err_d;
  logic             push, pop;

  pc_return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_plus1),
    .top       (stack_top),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  assign pc_plus1 = pc_q + WIDTH'(1);

  always_comb begin
    op          = resolve_pc_op(inc, load, call, ret);
    pc_d        = pc_q;
    wrapped_d   = 1'b0;
    stack_err_d = stack_err_q;
    push        = 1'b0;
    pop         = 1'b0;
    if (!halt) begin
      case (op)
        PC_RET: begin
          if (!stack_empty) begin
            pop  = 1'b1;
            pc_d = stack_top;
          end else begin
            stack_err_d = 1'b1;
          end
        end
        // A call on a full stack neither pushes nor jumps.
        PC_CALL: begin
          if (!stack_full) begin
            push = 1'b1;
            pc_d = din;
          end else begin
            stack_err_d = 1'b1;
          end
        end
        PC_LOAD: pc_d = din;
        PC_INC: begin
          pc_d      = pc_plus1;
          wrapped_d = (pc_q == '1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_VAL;
      wrapped_q   <= 1'b0;
      stack_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      wrapped_q   <= wrapped_d;
      stack_err_q <= stack_err_d;
    end
  end

  assign wrapped   = wrapped_q;
  assign stack_err = stack_err_q;
  assign cnt       = out_en ? pc_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_program_counter_stack.sv
// Bench for program_counter_stack: directed vector table, reset corner cases,
// then random strobes checked against a queue-based return-stack model.
module tb_program_counter_stack;

  localparam int         W     = 8;
  localparam logic [7:0] RVAL  = 8'h10;
  localparam int         DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst, inc, load, call, ret, halt, out_en;
  logic [W-1:0] din;
  wire  [W-1:0] cnt;
  logic [W-1:0] pc_q;
  logic         wrapped, stack_full, stack_empty, stack_err;

  int n_cmp = 0;
  int n_bad = 0;

  program_counter_stack #(
    .WIDTH       (W),
    .RESET_VAL   (RVAL),
    .STACK_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .inc         (inc),
    .load        (load),
    .call        (call),
    .ret         (ret),
    .halt        (halt),
    .din         (din),
    .out_en      (out_en),
    .cnt         (cnt),
    .pc_q        (pc_q),
    .wrapped     (wrapped),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       inc, load, call, ret, halt;
    logic [7:0] din;
    logic [7:0] pc;
    logic       wr, full, empty, err;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  int m_pc;
  int m_q[$];
  bit m_err, m_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic i, input logic l, input logic c, input logic r, input logic h,
                     input logic [7:0] d, input logic [7:0] p, input logic wr,
                     input logic f, input logic e, input logic er);
    vec_t v;
    v.inc = i; v.load = l; v.call = c; v.ret = r; v.halt = h; v.din = d;
    v.pc = p; v.wr = wr; v.full = f; v.empty = e; v.err = er;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    inc = 0; load = 0; call = 0; ret = 0; halt = 0; din = '0;
  endtask

  task automatic model_reset();
    m_pc = RVAL; m_q.delete(); m_err = 0; m_wr = 0;
  endtask

  // Behavioural rules: halt freezes, then ret > call > load > inc.
  task automatic model_step(input bit i, input bit l, input bit c, input bit r, input bit h,
                            input int d);
    m_wr = 0;
    if (h) return;
    if (r) begin
      if (m_q.size() > 0) m_pc = m_q.pop_back();
      else m_err = 1;
    end else if (c) begin
      if (m_q.size() < DEPTH) begin
        m_q.push_back((m_pc + 1) % 256);
        m_pc = d;
      end else m_err = 1;
    end else if (l) begin
      m_pc = d;
    end else if (i) begin
      m_wr = (m_pc == 255);
      m_pc = (m_pc + 1) % 256;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    rst = 1; out_en = 1;
    idle_inputs();
    #2;
    check("reset_pc", pc_q, RVAL);
    check("reset_cnt", cnt, RVAL);
    check("reset_wrapped", wrapped, 0);
    check("reset_empty", stack_empty, 1);
    check("reset_full", stack_full, 0);
    check("reset_err", stack_err, 0);
    @(negedge clk);
    rst = 0;

    //   inc load call ret halt din    pc   wr full empty err
    add(0, 1, 0, 0, 0, 8'hFE, 8'hFE, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 8'h00, 8'hFF, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0);
    add(1, 0, 0, 0, 0, 8'h00, 8'h01, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 8'h20, 8'h20, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 8'h80, 8'h80, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 8'hC0, 8'hC0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 8'h00, 8'h81, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 8'h00, 8'h21, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 8'h05, 8'h05, 0, 0, 1, 0);
    add(1, 1, 1, 0, 0, 8'h40, 8'h40, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) add(1, 0, 0, 0, 1, 8'h00, 8'h40, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 8'h00, 8'h06, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 8'hFF, 8'hFF, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 8'h30, 8'h30, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 8'h50, 8'h50, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 8'h51, 8'h51, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 8'h52, 8'h52, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 8'h53, 8'h53, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 8'h55, 8'h53, 0, 1, 0, 1);
    add(0, 0, 0, 1, 0, 8'h00, 8'h53, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 8'h00, 8'h52, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 8'h00, 8'h51, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 8'h00, 8'h01, 0, 0, 1, 1);
    add(0, 0, 0, 1, 0, 8'h00, 8'h01, 0, 0, 1, 1);

    foreach (vecs[n]) begin
      @(negedge clk);
      inc = vecs[n].inc; load = vecs[n].load; call = vecs[n].call;
      ret = vecs[n].ret; halt = vecs[n].halt; din = vecs[n].din;
      @(posedge clk);
      #1;
      $display("vec %0d: i%0b l%0b c%0b r%0b h%0b din=%02h -> pc=%02h wr=%0b full=%0b empty=%0b err=%0b",
               n, inc, load, call, ret, halt, din, pc_q, wrapped, stack_full, stack_empty, stack_err);
      check("vec_pc", pc_q, vecs[n].pc);
      check("vec_cnt", cnt, vecs[n].pc);
      check("vec_wrapped", wrapped, vecs[n].wr);
      check("vec_full", stack_full, vecs[n].full);
      check("vec_empty", stack_empty, vecs[n].empty);
      check("vec_err", stack_err, vecs[n].err);
    end

    // Asynchronous reset in the middle of a clock-high phase
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    $display("async reset: pc=%02h err=%0b empty=%0b", pc_q, stack_err, stack_empty);
    check("async_rst_pc", pc_q, RVAL);
    check("async_rst_cnt", cnt, RVAL);
    check("async_rst_err", stack_err, 0);
    check("async_rst_empty", stack_empty, 1);
    out_en = 0;
    #1;
    n_cmp++;
    if (cnt === RVAL) begin
      n_bad++;
      $display("FAIL cnt_released: got %0h expected bus released", cnt);
    end
    out_en = 1;
    @(negedge clk);
    rst = 0;

    // Reset asserted together with a call: nothing may be pushed
    @(negedge clk);
    rst = 1; call = 1; din = 8'h77;
    @(posedge clk);
    #1;
    check("rst_call_pc", pc_q, RVAL);
    check("rst_call_empty", stack_empty, 1);
    @(negedge clk);
    rst = 0; call = 0; ret = 1;
    @(posedge clk);
    #1;
    $display("reset+call then ret: pc=%02h err=%0b empty=%0b", pc_q, stack_err, stack_empty);
    check("rst_call_ret_pc", pc_q, RVAL);
    check("rst_call_ret_err", stack_err, 1);
    check("rst_call_ret_empty", stack_empty, 1);

    // Randomized strobes against the reference model
    pulse_reset();
    model_reset();
    for (int c = 0; c < 240; c++) begin
      bit ri, rl, rc, rr, rh, ro;
      int rd;
      if (c % 60 == 59) begin
        pulse_reset();
        model_reset();
      end
      ri = ($urandom_range(99) < 60);
      rl = ($urandom_range(99) < 15);
      rc = ($urandom_range(99) < 20);
      rr = ($urandom_range(99) < 20);
      rh = ($urandom_range(99) < 10);
      ro = ($urandom_range(99) < 70);
      rd = ($urandom_range(3) == 0) ? int'($urandom_range(255, 252)) : int'($urandom_range(255));
      @(negedge clk);
      inc = ri; load = rl; call = rc; ret = rr; halt = rh; out_en = ro; din = 8'(rd);
      model_step(ri, rl, rc, rr, rh, rd);
      @(posedge clk);
      #1;
      $display("rnd %0d: i%0b l%0b c%0b r%0b h%0b din=%02h -> pc=%02h (model %02h) depth=%0d",
               c, ri, rl, rc, rr, rh, rd, pc_q, m_pc, m_q.size());
      check("rnd_pc", pc_q, m_pc);
      check("rnd_wrapped", wrapped, m_wr);
      check("rnd_err", stack_err, m_err);
      check("rnd_full", stack_full, m_q.size() == DEPTH);
      check("rnd_empty", stack_empty, m_q.size() == 0);
      if (ro) check("rnd_cnt", cnt, m_pc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
